// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared FT245 timing defaults and transmit FSM encoding
//
// Purpose: constants and types shared by the FT245 transmitter and receiver.
// Ports:   none (package).
package usb_tx_pkg;

  // Default FT245 timing in clk cycles at 50 MHz.
  localparam int WR_HIGH_CYC_DEF = 3;   // WR high >= 50 ns
  localparam int RECOVER_CYC_DEF = 4;   // idle after WR falls, covers TXE# resync
  localparam int SI_CYC_DEF      = 13;  // SI low >= 250 ns

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4,
    ST_SI      = 3'd5
  } ft_state_e;

  // Bits needed to hold a down-counter loaded with n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/usb_tx_sync_fifo.sv
// rtl/usb_tx_sync_fifo.sv - single-clock byte FIFO with registered count
//
// Purpose: buffers bytes between the core and the FT245 write FSM.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en, wr_data     push request and data (ignored when full)
//   rd_en, rd_data     pop request; rd_data shows the head entry
//   full, empty        derived from the registered occupancy count
module usb_tx_sync_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    // Simultaneous push and pop leaves the count unchanged.
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - FT245 host-bound byte writer with WR strobe timing and SI flush
//
// Purpose: queues response bytes from the core and writes them to the FT245,
//          gated by TXE# and bus_gnt; issues an SI pulse on flush request.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   txe                 FT245 TXE# (active low, asynchronous to clk)
//   bus_gnt             receiver idle, d may be driven
//   in_data/in_valid    byte from the core; in_ready = FIFO not full
//   flush               one-cycle request for SI after queued bytes drain
//   wr, d_out, d_oe     FT245 WR strobe, data, and output enable for the d tristate
//   si                  FT245 SI/WU#, active low
//   busy                FSM active, bytes queued, or flush pending
module usb_tx
  import usb_tx_pkg::*;
#(
  parameter int FIFO_AW     = 4,
  parameter int WR_HIGH_CYC = WR_HIGH_CYC_DEF,
  parameter int RECOVER_CYC = RECOVER_CYC_DEF,
  parameter int SI_CYC      = SI_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       txe,
  input  logic       bus_gnt,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic       wr,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       si,
  output logic       busy
);

  // One down-counter serves all timed states, sized for the longest phase.
  localparam int CNT_MAX = (SI_CYC > WR_HIGH_CYC)
                         ? ((SI_CYC > RECOVER_CYC) ? SI_CYC : RECOVER_CYC)
                         : ((WR_HIGH_CYC > RECOVER_CYC) ? WR_HIGH_CYC : RECOVER_CYC);
  localparam int CNT_W   = cnt_width(CNT_MAX);

  ft_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic             d_oe_q, d_oe_d;
  logic [7:0]       d_out_q, d_out_d;
  logic             si_q, si_d;
  logic             flush_pend_q, flush_pend_d;
  logic             txe_meta_q, txe_s_q;

  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty;

  usb_tx_sync_fifo #(
    .AW (FIFO_AW),
    .DW (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // TXE# synchroniser; resets to 1 so nothing is written until the chip says ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txe_meta_q <= 1'b1;
      txe_s_q    <= 1'b1;
    end else begin
      txe_meta_q <= txe;
      txe_s_q    <= txe_meta_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    wr_d         = wr_q;
    d_oe_d       = d_oe_q;
    d_out_d      = d_out_q;
    si_d         = si_q;
    // A flush seen while SI is already low is absorbed by the pulse in progress.
    flush_pend_d = flush_pend_q | (flush && (state_q != ST_SI));
    fifo_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Data takes priority over SI so queued bytes always go out first.
        if (!fifo_empty && !txe_s_q && bus_gnt) begin
          fifo_pop = 1'b1;
          d_out_d  = fifo_rdata;
          d_oe_d   = 1'b1;
          state_d  = ST_SETUP;
        end else if (flush_pend_q && fifo_empty) begin
          si_d    = 1'b0;
          cnt_d   = CNT_W'(SI_CYC - 1);
          state_d = ST_SI;
        end
      end
      ST_SETUP: begin
        wr_d    = 1'b1;
        cnt_d   = CNT_W'(WR_HIGH_CYC - 1);
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          wr_d    = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // d_oe stays high this cycle to hold data past the WR falling edge.
        d_oe_d  = 1'b0;
        cnt_d   = CNT_W'(RECOVER_CYC - 1);
        state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (cnt_q == '0) state_d = ST_IDLE;
      end
      ST_SI: begin
        if (cnt_q == '0) begin
          si_d         = 1'b1;
          flush_pend_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      d_oe_q       <= 1'b0;
      d_out_q      <= 8'h00;
      si_q         <= 1'b1;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      d_oe_q       <= d_oe_d;
      d_out_q      <= d_out_d;
      si_q         <= si_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign wr       = wr_q;
  assign d_oe     = d_oe_q;
  assign d_out    = d_out_q;
  assign si       = si_q;
  assign in_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty || flush_pend_q;

endmodule

// File: tb/tb_usb_tx.sv
// tb/tb_usb_tx.sv - scoreboard testbench for usb_tx
module tb_usb_tx;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       txe_tb   = 1'b1;
  logic       txe_host = 1'b0;
  logic       txe;
  logic       bus_gnt  = 1'b1;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       flush    = 1'b0;
  logic       in_ready, wr, d_oe, si, busy;
  logic [7:0] d_out;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];

  assign txe = txe_tb | txe_host;

  always #5 clk = ~clk;

  usb_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .txe      (txe),
    .bus_gnt  (bus_gnt),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .wr       (wr),
    .d_out    (d_out),
    .d_oe     (d_oe),
    .si       (si),
    .busy     (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor / FT model: captures bytes on WR falling edge and checks strobe timing.
  logic wr_prev    = 1'b0;
  logic si_prev    = 1'b1;
  int   wr_w       = 0;
  int   si_w       = 0;
  int   si_pulses  = 0;
  int   cyc        = 0;
  int   last_rise  = -1;
  bit   period_chk = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      wr_prev   = 1'b0;
      si_prev   = 1'b1;
      wr_w      = 0;
      si_w      = 0;
      last_rise = -1;
    end else begin
      if (wr && !wr_prev) begin
        check("no_wr_while_txe", int'(txe), 0);
        check("d_oe_at_wr_rise", int'(d_oe), 1);
        if (period_chk && last_rise >= 0) check("byte_period", cyc - last_rise, 10);
        last_rise = period_chk ? cyc : -1;
      end
      if (wr) wr_w++;
      if (!wr && wr_prev) begin
        check("wr_high_width", wr_w, 3);
        check("d_oe_in_hold", int'(d_oe), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_byte", int'(d_out), -1);
        end else begin
          check("byte_data", int'(d_out), int'(exp_q.pop_front()));
        end
        wr_w = 0;
      end
      if (!si && si_prev) check("queue_empty_at_si", exp_q.size(), 0);
      if (!si) si_w++;
      if (si && !si_prev) begin
        check("si_low_width", si_w, 13);
        si_pulses++;
        si_w = 0;
      end
      wr_prev = wr;
      si_prev = si;
    end
  end

  // Host model: raises TXE# for 20 cycles after every 3rd byte when enabled.
  bit   host_en    = 1'b0;
  int   host_bytes = 0;
  int   host_cnt   = 0;
  logic host_prev  = 1'b0;

  always @(negedge clk) begin
    if (host_cnt > 0) begin
      host_cnt--;
      if (host_cnt == 0) txe_host = 1'b0;
    end
    if (host_en && host_prev && !wr) begin
      host_bytes++;
      if (host_bytes % 3 == 0) begin
        txe_host = 1'b1;
        host_cnt = 20;
      end
    end
    host_prev = wr;
  end

  task automatic push(input logic [7:0] b, output bit acc);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    acc      = in_ready;
    if (acc) exp_q.push_back(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(busy) + exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    int p0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wr", int'(wr), 0);
    check("rst_d_oe", int'(d_oe), 0);
    check("rst_d_out", int'(d_out), 0);
    check("rst_si", int'(si), 1);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    // 1: single byte
    txe_tb = 1'b0;
    repeat (4) @(negedge clk);
    push(8'h5A, acc);
    n = 0;
    do begin @(negedge clk); n++; end while (!d_oe && n < 20);
    check("t1_setup_d_oe", int'(d_oe), 1);
    check("t1_setup_data", int'(d_out), 8'h5A);
    check("t1_setup_wr", int'(wr), 0);
    wait_idle("t1_done", 50);

    // 2: fill FIFO with TXE# high, then drain
    txe_tb = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) push(8'(i), acc);
    @(negedge clk);
    check("t2_full_in_ready", int'(in_ready), 0);
    push(8'hFF, acc);
    check("t2_17th_refused", int'(acc), 0);
    check("t2_queued", exp_q.size(), 16);
    period_chk = 1'b1;
    txe_tb = 1'b0;
    wait_idle("t2_done", 300);
    period_chk = 1'b0;

    // 3: host pauses TXE# after every 3rd byte
    host_en = 1'b1;
    for (int i = 0; i < 9; i++) push(8'h30 + 8'(i), acc);
    wait_idle("t3_done", 600);
    repeat (25) @(negedge clk);
    host_en = 1'b0;
    check("t3_bytes_seen", host_bytes, 9);

    // 4: flush after queued bytes, second flush during SI absorbed
    p0 = si_pulses;
    push(8'hA0, acc);
    push(8'hA1, acc);
    push(8'hA2, acc);
    pulse_flush();
    push(8'hA3, acc);
    n = 0;
    while (si && n < 300) begin @(negedge clk); n++; end
    check("t4_si_seen", int'(si), 0);
    pulse_flush();
    wait_idle("t4_done", 100);
    repeat (30) @(negedge clk);
    check("t4_single_si", si_pulses - p0, 1);

    // 5: asynchronous reset mid-strobe
    push(8'h77, acc);
    n = 0;
    do begin @(negedge clk); n++; end while (!wr && n < 50);
    check("t5_in_strobe", int'(wr), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_wr", int'(wr), 0);
    check("t5_rst_d_oe", int'(d_oe), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_si", int'(si), 1);
    check("t5_in_ready", int'(in_ready), 1);
    check("t5_busy", int'(busy), 0);
    repeat (4) @(negedge clk);

    // 6: bus_gnt gating
    bus_gnt = 1'b0;
    push(8'h66, acc);
    repeat (10) @(negedge clk);
    check("t6_no_d_oe", int'(d_oe), 0);
    check("t6_no_wr", int'(wr), 0);
    check("t6_busy", int'(busy), 1);
    bus_gnt = 1'b1;
    @(negedge clk);
    check("t6_setup_d_oe", int'(d_oe), 1);
    check("t6_setup_data", int'(d_out), 8'h66);
    wait_idle("t6_done", 50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
